// File: rtl/pc_seq_ctrl.sv
// Fetch sequencer for the 32-bit pcreg: drives pcreg ena/data_in, runs the imem req/ack handshake,
// selects the next PC and flags fetch timeouts. Optional trap support is enabled with macro PC_TRAP_EN.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [7:0]  WAIT_MAX  = 8'd15,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic        pc_ena,
    output logic [31:0] pc_next,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        flush,
    output logic        fetch_err
`ifdef PC_TRAP_EN
    ,
    input  logic        trap_req,
    output logic [31:0] epc
`endif
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [7:0]  wait_cnt_r, wait_cnt_nxt_s;
    logic        fetch_err_r, fetch_err_nxt_s;
    logic [31:0] nxt_q_r, nxt_q_nxt_s;
    logic [31:0] sel_pc_s;
    logic        redirect_s;
    logic        trap_fetch_s;
    logic        trap_hold_s;
    logic        pc_ena_s, imem_req_s, flush_s;
    logic [31:0] pc_next_s;

`ifdef PC_TRAP_EN
    logic        trap_pend_r;
    logic [31:0] epc_r;

    // A trap seen without an ack stays pending until the fetch completes.
    assign trap_fetch_s = trap_req | trap_pend_r;
    assign trap_hold_s  = trap_req;
    assign epc          = epc_r;

    // Trap bookkeeping: pending flag and exception PC capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            trap_pend_r <= 1'b0;
            epc_r       <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ack && trap_fetch_s) begin
                        epc_r       <= pc_cur;
                        trap_pend_r <= 1'b0;
                    end else if (trap_req) begin
                        trap_pend_r <= 1'b1;
                    end else begin
                        trap_pend_r <= trap_pend_r;
                    end
                end
                ST_HOLD: begin
                    if (trap_req) begin
                        epc_r <= pc_cur;
                    end else begin
                        epc_r <= epc_r;
                    end
                end
                default: begin
                    trap_pend_r <= trap_pend_r;
                end
            endcase
        end
    end
`else
    assign trap_fetch_s = 1'b0;
    assign trap_hold_s  = 1'b0;
`endif

    // State, timeout counter, sticky error and captured next-PC registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_INIT;
            wait_cnt_r  <= 8'd0;
            fetch_err_r <= 1'b0;
            nxt_q_r     <= 32'h0000_0000;
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            fetch_err_r <= fetch_err_nxt_s;
            nxt_q_r     <= nxt_q_nxt_s;
        end
    end

    // Next-PC selection, handshake and state transitions; outputs held quiet while in reset.
    always_comb begin
        state_nxt_s     = state_r;
        wait_cnt_nxt_s  = wait_cnt_r;
        fetch_err_nxt_s = fetch_err_r;
        nxt_q_nxt_s     = nxt_q_r;
        pc_ena_s        = 1'b0;
        pc_next_s       = RESET_VEC;
        imem_req_s      = 1'b0;
        flush_s         = 1'b0;
        sel_pc_s        = pc_cur + PC_STEP;
        redirect_s      = 1'b0;

        if (trap_fetch_s) begin
            sel_pc_s   = TRAP_VEC;
            redirect_s = 1'b1;
        end else if (jmp) begin
            sel_pc_s   = jmp_target;
            redirect_s = 1'b1;
        end else if (br_taken) begin
            sel_pc_s   = br_target;
            redirect_s = 1'b1;
        end else begin
            sel_pc_s   = pc_cur + PC_STEP;
            redirect_s = 1'b0;
        end

        if (!rst) begin
            state_nxt_s = ST_INIT;
        end else begin
            case (state_r)
                ST_INIT: begin
                    pc_ena_s    = 1'b1;
                    pc_next_s   = RESET_VEC;
                    state_nxt_s = ST_FETCH;
                end
                ST_FETCH: begin
                    imem_req_s = 1'b1;
                    pc_next_s  = sel_pc_s;
                    if (imem_ack) begin
                        wait_cnt_nxt_s = 8'd0;
                        nxt_q_nxt_s    = sel_pc_s;
                        flush_s        = redirect_s;
                        if (stall) begin
                            state_nxt_s = ST_HOLD;
                        end else begin
                            pc_ena_s = 1'b1;
                        end
                    end else if (wait_cnt_r == WAIT_MAX) begin
                        // Timeout: flag it and keep requesting the same address.
                        fetch_err_nxt_s = 1'b1;
                        wait_cnt_nxt_s  = 8'd0;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (trap_hold_s) begin
                        nxt_q_nxt_s = TRAP_VEC;
                        flush_s     = 1'b1;
                        pc_next_s   = TRAP_VEC;
                    end else begin
                        pc_next_s = nxt_q_r;
                    end
                    if (!stall) begin
                        pc_ena_s    = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s = ST_INIT;
                end
            endcase
        end
    end

    assign pc_ena    = pc_ena_s;
    assign pc_next   = pc_next_s;
    assign imem_req  = imem_req_s;
    assign flush     = flush_s;
    assign fetch_err = fetch_err_r;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: the bench owns a pcreg model and a scoreboard of
// expected pc_next values pushed at stimulus time and popped on each pc_ena pulse.
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, pc_ena, imem_req, imem_ack, stall, jmp, br_taken, flush, fetch_err, trap_req;
    logic [31:0] pc_cur, pc_next, jmp_target, br_target, epc;
    logic        prev_ena = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pc_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pc_cur     (pc_cur),
        .pc_ena     (pc_ena),
        .pc_next    (pc_next),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .stall      (stall),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .flush      (flush),
        .fetch_err  (fetch_err)
`ifdef PC_TRAP_EN
        ,
        .trap_req   (trap_req),
        .epc        (epc)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic a, input logic st, input logic j, input logic [31:0] jt,
                         input logic b, input logic [31:0] bt, input logic t);
        imem_ack   = a;
        stall      = st;
        jmp        = j;
        jmp_target = jt;
        br_taken   = b;
        br_target  = bt;
        trap_req   = t;
        #1;
    endtask

    // Scoreboard pop on pc_ena, then clock edge and pcreg update.
    task automatic cyc();
        logic        e;
        logic [31:0] n;
        if (pc_ena === 1'b1) begin
            if (prev_ena) check_val("ena_b2b", pc_ena, 32'd0);
            if (exp_q.size() == 0) check_val("spurious_ena", pc_ena, 32'd0);
            else check_val("pc_next", pc_next, exp_q.pop_front());
        end
        e        = pc_ena;
        n        = pc_next;
        prev_ena = e;
        @(posedge clk);
        #1;
        if (e) pc_cur = n;
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_val({tag, "_req"}, imem_req, 32'd1);
        check_val({tag, "_flush"}, flush, 32'd0);
        cyc();
    endtask

    task automatic ack_cycle(input logic st, input logic j, input logic [31:0] jt, input logic b,
                             input logic [31:0] bt, input logic t, input logic [31:0] exp_pc,
                             input logic exp_fl, input string tag);
        drive(1'b1, st, j, jt, b, bt, t);
        check_val({tag, "_req"}, imem_req, 32'd1);
        check_val({tag, "_flush"}, flush, {31'd0, exp_fl});
        check_val({tag, "_ena"}, pc_ena, {31'd0, ~st});
        exp_q.push_back(exp_pc);
        cyc();
    endtask

    task automatic init_cycle(input string tag);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_val({tag, "_ena"}, pc_ena, 32'd1);
        check_val({tag, "_pcnext"}, pc_next, 32'h0000_0000);
        check_val({tag, "_req"}, imem_req, 32'd0);
        exp_q.push_back(32'h0000_0000);
        cyc();
    endtask

    initial begin
        rst    = 1'b0;
        pc_cur = 32'hDEAD_BEEF;
        // T1: reset held three cycles, outputs quiet
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            check_val("rst_ena", pc_ena, 32'd0);
            check_val("rst_req", imem_req, 32'd0);
            check_val("rst_flush", flush, 32'd0);
            check_val("rst_pcnext", pc_next, 32'h0000_0000);
            cyc();
        end
        check_val("rst_err", fetch_err, 32'd0);
        init_cycle("t1_init");
        idle("t1_first");

        // T2: sequential fetches and wrap-around
        ack_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h4, 1'b0, "t2_a");
        idle("t2_ia");
        ack_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h8, 1'b0, "t2_b");
        idle("t2_ib");
        ack_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'hC, 1'b0, "t2_c");
        check_val("t2_pcreg", pc_cur, 32'hC);
        idle("t2_ic");
        pc_cur = 32'hFFFF_FFFC;
        ack_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0, "wrap");
        check_val("wrap_pcreg", pc_cur, 32'h0);
        idle("wrap_i");

        // T3: jmp beats br in the same cycle; flush lasts one cycle
        ack_cycle(1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h100, 1'b1, "t3");
        idle("t3_after");
        ack_cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h300, 1'b0, 32'h300, 1'b1, "br");
        idle("br_after");

        // T4: stalled branch; redirects and acks ignored during hold
        ack_cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'h40, 1'b0, 32'h40, 1'b1, "t4");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0);
            check_val("hold_req", imem_req, 32'd0);
            check_val("hold_ena", pc_ena, 32'd0);
            check_val("hold_flush", flush, 32'd0);
            cyc();
        end
        drive(1'b1, 1'b0, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0);
        check_val("resume_ena", pc_ena, 32'd1);
        check_val("resume_req", imem_req, 32'd0);
        check_val("resume_flush", flush, 32'd0);
        cyc();
        check_val("resume_pcreg", pc_cur, 32'h40);

        // T5: timeout after WAIT_MAX+1 unacked cycles, sticky, retry continues
        check_val("t5_err_pre", fetch_err, 32'd0);
        for (int i = 0; i < 15; i++) idle("t5_wait");
        check_val("t5_err_early", fetch_err, 32'd0);
        idle("t5_wait16");
        check_val("t5_err_set", fetch_err, 32'd1);
        for (int i = 0; i < 3; i++) idle("t5_retry");
        ack_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h44, 1'b0, "t5_ack");
        check_val("t5_err_held", fetch_err, 32'd1);
        idle("t5_pending");

        // Reset with a request pending
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_val("mrst_req", imem_req, 32'd0);
        check_val("mrst_ena", pc_ena, 32'd0);
        cyc();
        check_val("mrst_err", fetch_err, 32'd0);
        init_cycle("mrst_init");
        idle("mrst_i");

        // Reset in HOLD discards the captured redirect
        ack_cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'h60, 1'b0, 32'h60, 1'b1, "hrst");
        exp_q.delete();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_val("hrst_hold_req", imem_req, 32'd0);
        cyc();
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_val("hrst_ena", pc_ena, 32'd0);
        cyc();
        init_cycle("hrst_init");
        idle("hrst_i");
        ack_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h4, 1'b0, "hrst_seq");

`ifdef PC_TRAP_EN
        // T6: trap beats jmp, then a trap held pending until ack
        idle("t6_i");
        pc_cur = 32'h24;
        ack_cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 32'h80, 1'b1, "t6");
        check_val("t6_epc", epc, 32'h24);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        check_val("t6p_flush", flush, 32'd0);
        cyc();
        ack_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'h80, 1'b1, "t6p");
        check_val("t6p_epc", epc, 32'h80);
`endif

        check_val("sb_drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
